turbo_block_receiver: RTL and testbench

//  Receive-side hard-decision checker for the 3-bit turbo symbol stream {p2,p1,sys}.

---
 rtl/turbo_block_receiver_if.sv | 28 ++
 rtl/turbo_block_receiver.sv | 170 +++++++++++++++++
 tb/tb_turbo_block_receiver.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/turbo_block_receiver_if.sv
// Symbol-in / result-out handshake bundle for turbo_block_receiver.
// The slave modport is the receiver; the master modport is the symbol source plus result consumer.
interface turbo_block_receiver_if #(
    parameter int BLOCK_LEN = 8
);
    localparam int CW = $clog2(BLOCK_LEN + 1);

    logic                 flush;
    logic [2:0]           sym_in;
    logic                 sym_valid;
    logic                 sym_ready;
    logic [BLOCK_LEN-1:0] data_out;
    logic [CW-1:0]        p1_err_cnt;
    logic [CW-1:0]        p2_err_cnt;
    logic                 blk_ok;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  flush, sym_in, sym_valid, out_ready,
        output sym_ready, data_out, p1_err_cnt, p2_err_cnt, blk_ok, out_valid
    );

    modport master (
        output flush, sym_in, sym_valid, out_ready,
        input  sym_ready, data_out, p1_err_cnt, p2_err_cnt, blk_ok, out_valid
    );
endinterface

// File: rtl/turbo_block_receiver.sv
// Hard-decision turbo block checker: buffers one {p2,p1,sys} block, re-encodes the systematic
// bits through both RSC encoders (encoder 2 via interleaver) and reports parity mismatch counts.
module turbo_block_receiver #(
    parameter int BLOCK_LEN = 8,
    parameter int IL_A      = 5,
    parameter int IL_B      = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    turbo_block_receiver_if.slave  bus
);
    localparam int CW = $clog2(BLOCK_LEN + 1);
    localparam int IW = $clog2(BLOCK_LEN);

    typedef enum logic [1:0] {ST_COLLECT, ST_CHECK, ST_OUTPUT} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        k_q, k_d;
    logic [BLOCK_LEN-1:0] sys_q, sys_d, p1_q, p1_d, p2_q, p2_d;
    logic [2:0]           enc1_q, enc1_d, enc2_q, enc2_d;
    logic [CW-1:0]        cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [BLOCK_LEN-1:0] data_q, data_d;
    logic [CW-1:0]        p1_cnt_q, p1_cnt_d, p2_cnt_q, p2_cnt_d;
    logic                 blk_ok_q, blk_ok_d;
    logic                 out_valid_q, out_valid_d;
    logic                 sym_ready_q, sym_ready_d;

    logic [IW-1:0] step_idx, il_idx;
    logic [31:0]   il_full;
    logic          u1, u2, a1, a2, par1, par2;

    assign step_idx = k_q[IW-1:0];
    // BLOCK_LEN is a power of two, so the modulo is just the low index bits.
    assign il_full  = 32'(IL_A) * 32'(k_q) + 32'(IL_B);
    assign il_idx   = il_full[IW-1:0];

    assign u1   = sys_q[step_idx];
    assign u2   = sys_q[il_idx];
    assign a1   = u1 ^ enc1_q[1] ^ enc1_q[2];
    assign a2   = u2 ^ enc2_q[1] ^ enc2_q[2];
    assign par1 = a1 ^ enc1_q[0] ^ enc1_q[2];
    assign par2 = a2 ^ enc2_q[0] ^ enc2_q[2];

    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a variable unassigned (no latches).
        state_d     = state_q;
        k_d         = k_q;
        sys_d       = sys_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        enc1_d      = enc1_q;
        enc2_d      = enc2_q;
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;
        data_d      = data_q;
        p1_cnt_d    = p1_cnt_q;
        p2_cnt_d    = p2_cnt_q;
        blk_ok_d    = blk_ok_q;
        out_valid_d = out_valid_q;
        sym_ready_d = sym_ready_q;

        unique case (state_q)
            ST_COLLECT: begin
                if (bus.sym_valid && sym_ready_q) begin
                    sys_d[step_idx] = bus.sym_in[0];
                    p1_d[step_idx]  = bus.sym_in[1];
                    p2_d[step_idx]  = bus.sym_in[2];
                    if (k_q == CW'(BLOCK_LEN - 1)) begin
                        k_d         = '0;
                        state_d     = ST_CHECK;
                        sym_ready_d = 1'b0;
                        enc1_d      = '0;
                        enc2_d      = '0;
                        cnt1_d      = '0;
                        cnt2_d      = '0;
                    end else begin
                        k_d = k_q + CW'(1);
                    end
                end
            end
            ST_CHECK: begin
                // One extra cycle after the last step publishes the finished counts.
                if (k_q == CW'(BLOCK_LEN)) begin
                    data_d      = sys_q;
                    p1_cnt_d    = cnt1_q;
                    p2_cnt_d    = cnt2_q;
                    blk_ok_d    = (cnt1_q == '0) && (cnt2_q == '0);
                    out_valid_d = 1'b1;
                    k_d         = '0;
                    state_d     = ST_OUTPUT;
                end else begin
                    enc1_d = {enc1_q[1], enc1_q[0], a1};
                    enc2_d = {enc2_q[1], enc2_q[0], a2};
                    cnt1_d = cnt1_q + CW'(par1 != p1_q[step_idx]);
                    cnt2_d = cnt2_q + CW'(par2 != p2_q[step_idx]);
                    k_d    = k_q + CW'(1);
                end
            end
            ST_OUTPUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    sym_ready_d = 1'b1;
                    state_d     = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase

        // Flush overrides any handshake in the same cycle, including the symbol write.
        if (bus.flush) begin
            state_d     = ST_COLLECT;
            k_d         = '0;
            sys_d       = sys_q;
            p1_d        = p1_q;
            p2_d        = p2_q;
            cnt1_d      = '0;
            cnt2_d      = '0;
            p1_cnt_d    = '0;
            p2_cnt_d    = '0;
            blk_ok_d    = 1'b1;
            out_valid_d = 1'b0;
            sym_ready_d = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments only; blocking here would race readers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_COLLECT;
            k_q         <= '0;
            // NOTE: the symbol buffers are flops, not RAM, so clearing them on reset is cheap.
            sys_q       <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            enc1_q      <= '0;
            enc2_q      <= '0;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
            data_q      <= '0;
            p1_cnt_q    <= '0;
            p2_cnt_q    <= '0;
            blk_ok_q    <= 1'b1;
            out_valid_q <= 1'b0;
            sym_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            sys_q       <= sys_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            enc1_q      <= enc1_d;
            enc2_q      <= enc2_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            data_q      <= data_d;
            p1_cnt_q    <= p1_cnt_d;
            p2_cnt_q    <= p2_cnt_d;
            blk_ok_q    <= blk_ok_d;
            out_valid_q <= out_valid_d;
            sym_ready_q <= sym_ready_d;
        end
    end

    assign bus.sym_ready  = sym_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.data_out   = data_q;
    assign bus.p1_err_cnt = p1_cnt_q;
    assign bus.p2_err_cnt = p2_cnt_q;
    assign bus.blk_ok     = blk_ok_q;
endmodule

// File: tb/tb_turbo_block_receiver.sv
// Scoreboard bench for turbo_block_receiver: expected results are queued when a block is sent
// and compared when the receiver hands a result over.
module tb_turbo_block_receiver;
    localparam int BL = 8;
    localparam int CW = $clog2(BL + 1);

    typedef struct packed {
        logic [BL-1:0] data;
        logic [CW-1:0] c1;
        logic [CW-1:0] c2;
        logic          ok;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    turbo_block_receiver_if #(.BLOCK_LEN(BL)) bus ();

    turbo_block_receiver #(.BLOCK_LEN(BL), .IL_A(5), .IL_B(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    res_t sb_q[$];
    res_t exp_r;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   n_push  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder straight from the code definition.
    function automatic res_t model(input logic [BL-1:0] sys, input logic [BL-1:0] p1,
                                   input logic [BL-1:0] p2);
        res_t       r;
        logic [2:0] s1, s2;
        logic       a, p, u;
        s1 = '0;
        s2 = '0;
        r.data = sys;
        r.c1 = '0;
        r.c2 = '0;
        for (int k = 0; k < BL; k++) begin
            a  = sys[k] ^ s1[1] ^ s1[2];
            p  = a ^ s1[0] ^ s1[2];
            if (p != p1[k]) r.c1 = r.c1 + CW'(1);
            s1 = {s1[1], s1[0], a};
            u  = sys[(5 * k + 3) % BL];
            a  = u ^ s2[1] ^ s2[2];
            p  = a ^ s2[0] ^ s2[2];
            if (p != p2[k]) r.c2 = r.c2 + CW'(1);
            s2 = {s2[1], s2[0], a};
        end
        r.ok = (r.c1 == '0) && (r.c2 == '0);
        return r;
    endfunction

    // Result handshake completes at the next rising edge; compare on the falling edge before it.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_out++;
            check("sb_depth", sb_q.size(), 1);
            if (sb_q.size() != 0) begin
                exp_r = sb_q.pop_front();
                check("data_out", bus.data_out, exp_r.data);
                check("p1_err_cnt", bus.p1_err_cnt, exp_r.c1);
                check("p2_err_cnt", bus.p2_err_cnt, exp_r.c2);
                check("blk_ok", bus.blk_ok, exp_r.ok);
            end
        end
    end

    task automatic send_sym(input logic [2:0] s, output bit ok);
        int t;
        t = 0;
        bus.sym_in    = s;
        bus.sym_valid = 1'b1;
        @(negedge clk);
        while (!bus.sym_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        ok = bus.sym_ready;
        @(posedge clk);
        #1;
        bus.sym_valid = 1'b0;
    endtask

    task automatic send_block(input logic [BL-1:0] sys, input logic [BL-1:0] p1,
                              input logic [BL-1:0] p2, input int gap, input bit expect_out);
        bit ok, all_ok;
        all_ok = 1'b1;
        for (int k = 0; k < BL; k++) begin
            if (k == BL - 1 && expect_out) begin
                sb_q.push_back(model(sys, p1, p2));
                n_push++;
            end
            send_sym({p2[k], p1[k], sys[k]}, ok);
            all_ok = all_ok & ok;
            if (k != BL - 1) repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        check("sym_accepted", all_ok, 1);
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1;
        check("drain", sb_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            n;
        bit            ok, stable, rdy_seen;
        logic [BL-1:0] r_sys [4];
        logic [BL-1:0] r_p1  [4];
        logic [BL-1:0] r_p2  [4];
        logic [BL-1:0] snap_data;
        logic [CW-1:0] snap_c1, snap_c2;
        logic          snap_ok;

        bus.flush     = 1'b0;
        bus.sym_valid = 1'b0;
        bus.sym_in    = 3'b000;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_sym_ready", bus.sym_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_p1_cnt", bus.p1_err_cnt, 0);
        check("rst_p2_cnt", bus.p2_err_cnt, 0);
        check("rst_blk_ok", bus.blk_ok, 1);

        // All-zero block, latency measured with the consumer stalled.
        send_block('0, '0, '0, 0, 1'b1);
        wait_out_valid(n);
        check("latency", n, BL + 1);
        check("zero_data", bus.data_out, 8'h00);
        check("zero_ok", bus.blk_ok, 1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drop_out_valid", bus.out_valid, 0);
        check("rise_sym_ready", bus.sym_ready, 1);

        // Impulse: clean, then with p1[3] and p2[5] inverted.
        send_block(8'h01, 8'h4F, 8'h9E, 0, 1'b1);
        wait_out_valid(n);
        check("imp_data", bus.data_out, 8'h01);
        check("imp_p1", bus.p1_err_cnt, 0);
        check("imp_p2", bus.p2_err_cnt, 0);
        check("imp_ok", bus.blk_ok, 1);
        wait_drain();
        send_block(8'h01, 8'h4F ^ 8'h08, 8'h9E ^ 8'h20, 0, 1'b1);
        wait_out_valid(n);
        check("err_p1", bus.p1_err_cnt, 1);
        check("err_p2", bus.p2_err_cnt, 1);
        check("err_ok", bus.blk_ok, 0);
        wait_drain();

        // Backpressure for 20 cycles.
        bus.out_ready = 1'b0;
        send_block(BL'($urandom), BL'($urandom), BL'($urandom), 0, 1'b1);
        wait_out_valid(n);
        check("bp_valid_seen", bus.out_valid, 1);
        snap_data = bus.data_out;
        snap_c1   = bus.p1_err_cnt;
        snap_c2   = bus.p2_err_cnt;
        snap_ok   = bus.blk_ok;
        stable    = 1'b1;
        rdy_seen  = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (!bus.out_valid || bus.data_out !== snap_data || bus.p1_err_cnt !== snap_c1 ||
                bus.p2_err_cnt !== snap_c2 || bus.blk_ok !== snap_ok) stable = 1'b0;
            if (bus.sym_ready) rdy_seen = 1'b1;
        end
        check("bp_stable", stable, 1);
        check("bp_sym_ready_low", rdy_seen, 0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_drop_out_valid", bus.out_valid, 0);
        check("bp_sym_ready", bus.sym_ready, 1);

        // Two random blocks back-to-back with sym_valid 1 of 3 cycles, then the same gapless.
        for (int i = 0; i < 2; i++) begin
            r_sys[i] = BL'($urandom);
            r_p1[i]  = BL'($urandom);
            r_p2[i]  = BL'($urandom);
        end
        for (int i = 0; i < 2; i++) send_block(r_sys[i], r_p1[i], r_p2[i], 2, 1'b1);
        for (int i = 0; i < 2; i++) send_block(r_sys[i], r_p1[i], r_p2[i], 0, 1'b1);
        wait_drain();

        // Flush after 5 symbols, colliding with a symbol handshake, then an all-zero block.
        for (int k = 0; k < 5; k++) send_sym(3'b111, ok);
        bus.flush     = 1'b1;
        bus.sym_valid = 1'b1;
        bus.sym_in    = 3'b111;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.sym_valid = 1'b0;
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_sym_ready", bus.sym_ready, 1);
        check("flush_p1_cnt", bus.p1_err_cnt, 0);
        check("flush_p2_cnt", bus.p2_err_cnt, 0);
        send_block('0, '0, '0, 0, 1'b1);
        wait_out_valid(n);
        check("flush_blk_ok", bus.blk_ok, 1);
        check("flush_data", bus.data_out, 8'h00);
        wait_drain();

        // Async reset pulse while in CHECK; the partial result must vanish.
        send_block(8'hA5, 8'h3C, 8'hC3, 0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", bus.out_valid, 0);
        check("rst_mid_sym_ready", bus.sym_ready, 1);
        check("rst_mid_blk_ok", bus.blk_ok, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_block(8'h01, 8'h4F, 8'h9E, 0, 1'b1);
        wait_drain();

        repeat (BL + 4) @(posedge clk);
        #1;
        check("out_count", n_out, n_push);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
